// File: rtl/reg_change_monitor.sv
// Debounced change detector with valid/ready reporting and sticky overrun.
// Optional change counter enabled by REG_CHANGE_MONITOR_COUNT_EN.
module reg_change_monitor #(
  parameter int             WIDTH         = 32,
  parameter int             STABLE_CYCLES = 2,
  parameter logic [WIDTH-1:0] MASK        = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] INIT_VALUE  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value_i,
  output logic [WIDTH-1:0] dat_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             overrun_o,
  input  logic             overrun_clr_i,
  output logic [15:0]      change_count_o
);

  typedef enum logic {IDLE, QUAL} state_t;

  localparam logic [3:0] SC = 4'(STABLE_CYCLES);

  state_t           state, state_n;
  logic [WIDTH-1:0] ref_q, cand_q, cand_n;
  logic [3:0]       cnt_q, cnt_n, cnt_inc;
  logic             qual;
  logic [WIDTH-1:0] vm, refm, candm;

  assign vm      = value_i & MASK;
  assign refm    = ref_q & MASK;
  assign candm   = cand_q & MASK;
  assign cnt_inc = cnt_q + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cand_q <= INIT_VALUE;
      cnt_q  <= 4'd0;
    end else begin
      state  <= state_n;
      cand_q <= cand_n;
      cnt_q  <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand_q;
    cnt_n   = cnt_q;
    qual    = 1'b0;
    unique case (state)
      IDLE: begin
        if (vm != refm) begin
          cand_n = value_i;
          cnt_n  = 4'd1;
          if (SC == 4'd1) qual = 1'b1;
          else state_n = QUAL;
        end
      end
      QUAL: begin
        unique case (1'b1)
          (vm == candm): begin
            cnt_n = cnt_inc;
            if (cnt_inc == SC) begin
              qual    = 1'b1;
              state_n = IDLE;
            end
          end
          // Change reverted before it settled.
          (vm != candm) && (vm == refm): begin
            state_n = IDLE;
          end
          default: begin
            cand_n = value_i;
            cnt_n  = 4'd1;
          end
        endcase
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q     <= INIT_VALUE;
      dat_o     <= INIT_VALUE;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      if (qual) begin
        ref_q   <= value_i;
        dat_o   <= value_i;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      if (qual && valid_o && !ready_i) overrun_o <= 1'b1;
      else if (overrun_clr_i) overrun_o <= 1'b0;
    end
  end

`ifdef REG_CHANGE_MONITOR_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) count_q <= 16'h0000;
    else if (qual && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
  end

  assign change_count_o = count_q;
`else
  assign change_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_reg_change_monitor.sv
// Scoreboard bench for reg_change_monitor.
// Three instances cover default, masked and single-cycle configurations.
module tb_reg_change_monitor;

`ifdef REG_CHANGE_MONITOR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] value = 32'h0;
  logic        ready = 1'b1;
  logic        clr = 1'b0;

  logic [31:0] dat_a, dat_b, dat_c;
  logic        val_a, val_b, val_c;
  logic        ovr_a, ovr_b, ovr_c;
  logic [15:0] cnt_a, cnt_b, cnt_c;

  int          n_checks = 0;
  int          n_fail = 0;
  int          mon_sel = 0;
  logic [31:0] q[$];
  logic [31:0] exp_v;
  logic [31:0] mon_dat;
  logic        mon_valid;

  always #5 clk = ~clk;

  reg_change_monitor #(.STABLE_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .value_i(value), .dat_o(dat_a),
    .valid_o(val_a), .ready_i(ready), .overrun_o(ovr_a),
    .overrun_clr_i(clr), .change_count_o(cnt_a));

  reg_change_monitor #(.STABLE_CYCLES(2), .MASK(32'h0000_00FF)) u_mask (
    .clk(clk), .rst(rst), .value_i(value), .dat_o(dat_b),
    .valid_o(val_b), .ready_i(ready), .overrun_o(ovr_b),
    .overrun_clr_i(clr), .change_count_o(cnt_b));

  reg_change_monitor #(.STABLE_CYCLES(1)) u_sc1 (
    .clk(clk), .rst(rst), .value_i(value), .dat_o(dat_c),
    .valid_o(val_c), .ready_i(ready), .overrun_o(ovr_c),
    .overrun_clr_i(clr), .change_count_o(cnt_c));

  always_comb begin
    mon_dat   = dat_a;
    mon_valid = val_a;
    case (mon_sel)
      1: begin mon_dat = dat_b; mon_valid = val_b; end
      2: begin mon_dat = dat_c; mon_valid = val_c; end
      default: ;
    endcase
  end

  always @(negedge clk) begin
    if (!rst && mon_valid && ready) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_report dat=%h required none", mon_dat);
      end else begin
        exp_v = q.pop_front();
        if (mon_dat !== exp_v) begin
          n_fail++;
          $display("FAIL report_dat got %h required %h", mon_dat, exp_v);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    value = 32'h0;
    clr = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({val_a, ovr_a, dat_a, cnt_a} !== 50'h0) begin
      n_fail++;
      $display("FAIL reset_state got v=%b o=%b d=%h c=%h required 0",
               val_a, ovr_a, dat_a, cnt_a);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (val_a !== 1'b0 || ovr_a !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_after_reset cyc=%0d v=%b o=%b required 0 0",
                 i, val_a, ovr_a);
      end
    end
  endtask

  task automatic test_step();
    mon_sel = 0;
    do_reset();
    value = 32'h1234_5678;
    q.push_back(32'h1234_5678);
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (val_a !== 1'b0) begin
      n_fail++;
      $display("FAIL step_e0_valid got %b required 0", val_a);
    end
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (val_a !== 1'b1 || dat_a !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL step_e1 got v=%b d=%h required 1 12345678",
               val_a, dat_a);
    end
    n_checks++;
    if (cnt_a !== (CNT_EN ? 16'd1 : 16'd0)) begin
      n_fail++;
      $display("FAIL step_count got %h required %h",
               cnt_a, CNT_EN ? 16'd1 : 16'd0);
    end
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (val_a !== 1'b0) begin
      n_fail++;
      $display("FAIL step_e2_valid got %b required 0", val_a);
    end
  endtask

  task automatic test_glitch();
    mon_sel = 0;
    do_reset();
    value = 32'hAA;
    @(posedge clk); #1 value = 32'h0;
    repeat (5) @(posedge clk);
    #1 value = 32'h5;
    @(posedge clk); #1 value = 32'h9;
    q.push_back(32'h9);
    repeat (6) @(posedge clk);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL glitch_drain pending=%0d required 0", q.size());
    end
  endtask

  task automatic test_mask();
    mon_sel = 1;
    do_reset();
    value = 32'hFF00_0000;
    repeat (5) @(posedge clk);
    #1 value = 32'hFF00_0001;
    q.push_back(32'hFF00_0001);
    repeat (5) @(posedge clk);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (q.size() != 0 || dat_b !== 32'hFF00_0001) begin
      n_fail++;
      $display("FAIL mask_report pending=%0d d=%h required 0 ff000001",
               q.size(), dat_b);
    end
    mon_sel = 0;
  endtask

  task automatic test_overrun();
    mon_sel = 0;
    do_reset();
    ready = 1'b0;
    value = 32'h1;
    repeat (3) @(posedge clk);
    #1 value = 32'h2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (val_a !== 1'b1 || dat_a !== 32'h2 || ovr_a !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set got v=%b d=%h o=%b required 1 2 1",
               val_a, dat_a, ovr_a);
    end
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ovr_a !== 1'b0 || val_a !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_clr got o=%b v=%b required 0 1", ovr_a, val_a);
    end
    @(posedge clk); #1;
    q.push_back(32'h2);
    ready = 1'b1;
    @(posedge clk); #1 ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (val_a !== 1'b0 || q.size() != 0) begin
      n_fail++;
      $display("FAIL overrun_drain got v=%b pending=%0d required 0 0",
               val_a, q.size());
    end
    @(posedge clk); #1 value = 32'h3;
    @(posedge clk); #1;
    rst = 1'b1;
    value = 32'h0;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (val_a !== 1'b0 || dat_a !== 32'h0 || ovr_a !== 1'b0) begin
      n_fail++;
      $display("FAIL midqual_reset got v=%b d=%h o=%b required 0 0 0",
               val_a, dat_a, ovr_a);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (val_a !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_quiet got v=%b required 0", val_a);
    end
  endtask

  task automatic test_back_to_back();
    mon_sel = 2;
    ready = 1'b1;
    do_reset();
    for (int i = 0; i < 70000; i++) begin
      value = (i % 2 == 0) ? 32'h3 : 32'h4;
      q.push_back(value);
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (q.size() != 0 || ovr_c !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain pending=%0d o=%b required 0 0",
               q.size(), ovr_c);
    end
    n_checks++;
    if (cnt_c !== (CNT_EN ? 16'hFFFF : 16'h0000)) begin
      n_fail++;
      $display("FAIL b2b_count got %h required %h",
               cnt_c, CNT_EN ? 16'hFFFF : 16'h0000);
    end
    mon_sel = 0;
  endtask

  initial begin
    test_reset();
    test_step();
    test_glitch();
    test_mask();
    test_overrun();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
